// File: rtl/key_event_qualifier.sv
// Multi-channel keypad press qualifier: per-key synchroniser, press/release debounce FSM,
// optional auto-repeat, and a lowest-index event encoder. All outputs are registered.
module key_event_qualifier #(
    parameter int unsigned NUM_KEYS       = 10,
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned PRESS_CYCLES   = 4,
    parameter int unsigned RELEASE_CYCLES = 4,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned REPEAT_EN      = 0,
    parameter int unsigned REPEAT_DELAY   = 16,
    parameter int unsigned REPEAT_PERIOD  = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_KEYS-1:0]         key_raw,
    output logic [NUM_KEYS-1:0]         key_level,
    output logic [NUM_KEYS-1:0]         key_press,
    output logic [NUM_KEYS-1:0]         key_release,
    output logic [NUM_KEYS-1:0]         key_repeat,
    output logic                        key_valid,
    output logic [$clog2(NUM_KEYS)-1:0] key_code,
    output logic                        key_multi
);

    localparam int unsigned      CODE_W   = $clog2(NUM_KEYS);
    localparam logic [CNT_W-1:0] PRESS_T  = CNT_W'(PRESS_CYCLES);
    localparam logic [CNT_W-1:0] REL_T    = CNT_W'(RELEASE_CYCLES);
    localparam logic [CNT_W-1:0] DELAY_T  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] PERIOD_T = CNT_W'(REPEAT_PERIOD);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS_QUAL,
        S_HELD,
        S_REL_QUAL
    } state_t;

    logic [NUM_KEYS-1:0] r_sync [SYNC_STAGES];
    logic [NUM_KEYS-1:0] w_key_s;

    state_t              r_state     [NUM_KEYS];
    logic [CNT_W-1:0]    r_cnt       [NUM_KEYS];
    logic [CNT_W-1:0]    r_rpt       [NUM_KEYS];
    logic [NUM_KEYS-1:0] r_rpt_first;

    state_t              w_state_nxt [NUM_KEYS];
    logic [CNT_W-1:0]    w_cnt_nxt   [NUM_KEYS];
    logic [CNT_W-1:0]    w_rpt_nxt   [NUM_KEYS];
    logic [NUM_KEYS-1:0] w_rpt_first_nxt;
    logic [NUM_KEYS-1:0] w_press;
    logic [NUM_KEYS-1:0] w_release;
    logic [NUM_KEYS-1:0] w_repeat;
    logic [NUM_KEYS-1:0] w_level;
    logic [NUM_KEYS-1:0] w_ev;
    logic [CODE_W-1:0]   w_code;
    logic                w_multi;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
        end else begin
            r_sync[0] <= key_raw;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
        end
    end

    assign w_key_s = r_sync[SYNC_STAGES-1];

    always_comb begin
        w_press         = '0;
        w_release       = '0;
        w_repeat        = '0;
        w_level         = '0;
        w_rpt_first_nxt = r_rpt_first;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            w_rpt_nxt[i]   = r_rpt[i];
            case (r_state[i])
                S_IDLE: begin
                    w_cnt_nxt[i] = '0;
                    w_rpt_nxt[i] = '0;
                    if (w_key_s[i]) begin
                        if (PRESS_T == CNT_W'(1)) begin
                            w_state_nxt[i]     = S_HELD;
                            w_press[i]         = 1'b1;
                            w_rpt_first_nxt[i] = 1'b1;
                        end else begin
                            w_state_nxt[i] = S_PRESS_QUAL;
                            w_cnt_nxt[i]   = CNT_W'(1);
                        end
                    end
                end
                S_PRESS_QUAL: begin
                    if (!w_key_s[i]) begin
                        w_state_nxt[i] = S_IDLE;
                        w_cnt_nxt[i]   = '0;
                    end else if (sat_inc(r_cnt[i]) == PRESS_T) begin
                        w_state_nxt[i]     = S_HELD;
                        w_press[i]         = 1'b1;
                        w_cnt_nxt[i]       = '0;
                        w_rpt_nxt[i]       = '0;
                        w_rpt_first_nxt[i] = 1'b1;
                    end else begin
                        w_cnt_nxt[i] = sat_inc(r_cnt[i]);
                    end
                end
                S_HELD: begin
                    if (!w_key_s[i]) begin
                        if (REL_T == CNT_W'(1)) begin
                            w_state_nxt[i] = S_IDLE;
                            w_release[i]   = 1'b1;
                            w_cnt_nxt[i]   = '0;
                            w_rpt_nxt[i]   = '0;
                        end else begin
                            w_state_nxt[i] = S_REL_QUAL;
                            w_cnt_nxt[i]   = CNT_W'(1);
                        end
                    end else if (REPEAT_EN != 0) begin
                        // First repeat waits DELAY, later ones PERIOD; counter restarts on each pulse.
                        if (sat_inc(r_rpt[i]) == (r_rpt_first[i] ? DELAY_T : PERIOD_T)) begin
                            w_repeat[i]        = 1'b1;
                            w_rpt_nxt[i]       = '0;
                            w_rpt_first_nxt[i] = 1'b0;
                        end else begin
                            w_rpt_nxt[i] = sat_inc(r_rpt[i]);
                        end
                    end
                end
                S_REL_QUAL: begin
                    if (w_key_s[i]) begin
                        w_state_nxt[i] = S_HELD;
                        w_cnt_nxt[i]   = '0;
                    end else if (sat_inc(r_cnt[i]) == REL_T) begin
                        w_state_nxt[i] = S_IDLE;
                        w_release[i]   = 1'b1;
                        w_cnt_nxt[i]   = '0;
                        w_rpt_nxt[i]   = '0;
                    end else begin
                        w_cnt_nxt[i] = sat_inc(r_cnt[i]);
                    end
                end
                default: w_state_nxt[i] = S_IDLE;
            endcase
            w_level[i] = (w_state_nxt[i] == S_HELD) || (w_state_nxt[i] == S_REL_QUAL);
        end
    end

    // Encoder works on next-cycle pulse vectors so code/valid register alongside the pulses.
    always_comb begin
        w_ev   = w_press | w_repeat;
        w_code = '0;
        for (int unsigned i = NUM_KEYS; i > 0; i--) begin
            if (w_ev[i-1]) w_code = CODE_W'(i - 1);
        end
        w_multi = (w_level & (w_level - NUM_KEYS'(1))) != '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                r_state[i] <= S_IDLE;
                r_cnt[i]   <= '0;
                r_rpt[i]   <= '0;
            end
            r_rpt_first <= '0;
            key_level   <= '0;
            key_press   <= '0;
            key_release <= '0;
            key_repeat  <= '0;
            key_valid   <= 1'b0;
            key_code    <= '0;
            key_multi   <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
                r_rpt[i]   <= w_rpt_nxt[i];
            end
            r_rpt_first <= w_rpt_first_nxt;
            key_level   <= w_level;
            key_press   <= w_press;
            key_release <= w_release;
            key_repeat  <= w_repeat;
            key_valid   <= |w_ev;
            key_code    <= w_code;
            key_multi   <= w_multi;
        end
    end

endmodule
